// File: rtl/id_pkg.sv
// Shared decode constants for the 8-bit core: opcodes, ALU function codes, strobe bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_pkg;

  localparam int NREG = 4;

  // Opcode field inst[7:5]
  localparam logic [2:0] OP_ALU   = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_JUMP  = 3'b100;
  localparam logic [2:0] OP_BEQ   = 3'b101;
  localparam logic [2:0] OP_BNE   = 3'b110;
  localparam logic [2:0] OP_IO    = 3'b111;

  // ALU function codes, shared with execute
  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_SUB = 3'b001;
  localparam logic [2:0] F_AND = 3'b010;
  localparam logic [2:0] F_OR  = 3'b011;
  localparam logic [2:0] F_XOR = 3'b100;
  localparam logic [2:0] F_NOT = 3'b101;
  localparam logic [2:0] F_SHL = 3'b110;
  localparam logic [2:0] F_SHR = 3'b111;

  // Control strobes handed to execute
  typedef struct packed {
    logic j;
    logic jc;
    logic ina;
    logic rm;
    logic wm;
    logic sin;
    logic sout;
    logic wrout;
    logic neq;
  } strb_t;

endpackage

// File: rtl/id_regfile.sv
// 4x8 general register file: one combinational read port, one synchronous write port.
// Latency: read is zero-cycle; a write is visible after the rising edge (no bypass).
// Backpressure: none; a write is accepted on every enabled edge.
module id_regfile
  import id_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] regs [NREG];

  // Register array: async clear, write on rising edge when enabled
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = regs[raddr];

endmodule

// File: rtl/id.sv
// Instruction decode: ALU function, sign-extended immediate, control strobes, register read/write.
// Latency: all outputs combinational from inputs; register writes land at the rising edge.
// Backpressure: none; one instruction decoded per cycle, no stall path.
module id
  import id_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] PC,
  input  logic [7:0] inst,
  input  logic [7:0] data,
  input  logic       WR,
  output logic [7:0] regVal,
  output logic [7:0] extsinal,
  output logic [2:0] funct,
  output logic       J,
  output logic       JC,
  output logic       INA,
  output logic       RM,
  output logic       WM,
  output logic       SIN,
  output logic       SOUT,
  output logic       WROut,
  output logic       NEQ,
  output logic [7:0] PCout
);

  logic [2:0] opcode;
  logic [2:0] sub;
  logic [1:0] rs;
  logic [4:0] imm5;
  logic [7:0] rf_rdata;
  strb_t      strb_dec;
  strb_t      strb_out;

  assign opcode = inst[7:5];
  assign sub    = inst[4:2];
  assign rs     = inst[1:0];
  assign imm5   = inst[4:0];

  // Register file; write address is rs of the instruction currently presented
  id_regfile u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (WR),
    .waddr   (rs),
    .wdata   (data),
    .raddr   (rs),
    .rdata   (rf_rdata)
  );

  // Opcode decode into ALU function and raw strobes
  always_comb begin
    strb_dec = '0;
    funct    = F_ADD;
    case (opcode)
      OP_ALU: begin
        funct          = sub;
        strb_dec.wrout = 1'b1;
      end
      OP_ADDI: begin
        strb_dec.ina   = 1'b1;
        strb_dec.wrout = 1'b1;
      end
      OP_LOAD: begin
        strb_dec.ina   = 1'b1;
        strb_dec.rm    = 1'b1;
        strb_dec.wrout = 1'b1;
      end
      OP_STORE: begin
        strb_dec.ina = 1'b1;
        strb_dec.wm  = 1'b1;
      end
      OP_JUMP: begin
        strb_dec.j = 1'b1;
      end
      OP_BEQ: begin
        funct       = F_SUB;
        strb_dec.jc = 1'b1;
      end
      OP_BNE: begin
        funct        = F_SUB;
        strb_dec.jc  = 1'b1;
        strb_dec.neq = 1'b1;
      end
      OP_IO: begin
        if (!inst[4]) begin
          strb_dec.sin   = 1'b1;
          strb_dec.wrout = 1'b1;
        end else begin
          strb_dec.sout = 1'b1;
        end
      end
      default: begin
        strb_dec = '0;
      end
    endcase
  end

  // Reset gating: strobes and register read are held at zero while reset is low
  always_comb begin
    strb_out = reset_n ? strb_dec : '0;
    regVal   = reset_n ? rf_rdata : 8'h00;
  end

  assign J     = strb_out.j;
  assign JC    = strb_out.jc;
  assign INA   = strb_out.ina;
  assign RM    = strb_out.rm;
  assign WM    = strb_out.wm;
  assign SIN   = strb_out.sin;
  assign SOUT  = strb_out.sout;
  assign WROut = strb_out.wrout;
  assign NEQ   = strb_out.neq;

  assign extsinal = {{3{imm5[4]}}, imm5};
  assign PCout    = PC + 8'd1;

endmodule

// File: tb/tb_id.sv
// Bench for the decode stage: directed checks plus randomized instructions against a table model.
// Latency: checks combinational outputs mid-cycle, register contents after each edge.
// Backpressure: n/a.
module tb_id;

  logic       clock;
  logic       reset_n;
  logic [7:0] PC;
  logic [7:0] inst;
  logic [7:0] data;
  logic       WR;
  logic [7:0] regVal;
  logic [7:0] extsinal;
  logic [2:0] funct;
  logic       J, JC, INA, RM, WM, SIN, SOUT, WROut, NEQ;
  logic [7:0] PCout;

  int errors = 0;
  int checks = 0;
  logic [7:0] mreg [4];

  id dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .PC       (PC),
    .inst     (inst),
    .data     (data),
    .WR       (WR),
    .regVal   (regVal),
    .extsinal (extsinal),
    .funct    (funct),
    .J        (J),
    .JC       (JC),
    .INA      (INA),
    .RM       (RM),
    .WM       (WM),
    .SIN      (SIN),
    .SOUT     (SOUT),
    .WROut    (WROut),
    .NEQ      (NEQ),
    .PCout    (PCout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected strobes {J,JC,INA,RM,WM,SIN,SOUT,WROut,NEQ} straight from the opcode table
  function automatic logic [8:0] exp_strobes(input logic [7:0] i);
    case (i[7:5])
      3'd0: return 9'b000000010;
      3'd1: return 9'b001000010;
      3'd2: return 9'b001100010;
      3'd3: return 9'b001010000;
      3'd4: return 9'b100000000;
      3'd5: return 9'b010000000;
      3'd6: return 9'b010000001;
      default: return i[4] ? 9'b000000100 : 9'b000001010;
    endcase
  endfunction

  function automatic logic [2:0] exp_funct(input logic [7:0] i);
    int op;
    op = int'(i[7:5]);
    if (op == 0) return i[4:2];
    if (op == 5 || op == 6) return 3'd1;
    return 3'd0;
  endfunction

  function automatic logic [7:0] exp_ext(input logic [7:0] i);
    int v;
    v = int'(i[4:0]);
    if (v >= 16) v = v - 32;
    return 8'(v);
  endfunction

  // Compare every output against the model for the currently driven inputs
  task automatic check_all(input string tag);
    logic [8:0] s;
    logic [7:0] rv;
    s  = reset_n ? exp_strobes(inst) : 9'd0;
    rv = reset_n ? mreg[inst[1:0]] : 8'h00;
    chk({tag, ".strobes"}, {J, JC, INA, RM, WM, SIN, SOUT, WROut, NEQ}, s);
    chk({tag, ".funct"}, funct, exp_funct(inst));
    chk({tag, ".ext"}, extsinal, exp_ext(inst));
    chk({tag, ".regVal"}, regVal, rv);
    chk({tag, ".PCout"}, PCout, (int'(PC) + 1) % 256);
  endtask

  // Drive at negedge, check mid-cycle, then let the rising edge commit to the model
  task automatic step(input string tag, input logic [7:0] i, input logic [7:0] d,
                      input logic w, input logic [7:0] pc);
    @(negedge clock);
    inst = i; data = d; WR = w; PC = pc;
    #2;
    check_all(tag);
    @(posedge clock);
    if (w && reset_n) mreg[i[1:0]] = d;
  endtask

  initial begin
    reset_n = 1'b0; PC = 8'h0F; inst = 8'h00; data = 8'h00; WR = 1'b0;
    for (int k = 0; k < 4; k++) mreg[k] = 8'h00;
    #2;
    chk("rst.regVal", regVal, 8'h00);
    chk("rst.strobes", {J, JC, INA, RM, WM, SIN, SOUT, WROut, NEQ}, 9'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #2;
    chk("rel.regVal", regVal, 8'h00);
    chk("rel.funct", funct, 3'd0);
    chk("rel.WROut", WROut, 1'b1);
    chk("rel.ext", extsinal, 8'h00);
    chk("rel.PCout", PCout, 8'h10);

    // Write then read R2
    step("wr", 8'h12, 8'h55, 1'b1, 8'h20);
    chk("wr.funct4", funct, 3'd4);
    chk("wr.extF2", extsinal, 8'hF2);
    @(negedge clock);
    chk("wr.after", regVal, 8'h55);
    step("rd", 8'h16, 8'h5F, 1'b0, 8'h21);
    chk("rd.funct5", funct, 3'd5);
    chk("rd.extF6", extsinal, 8'hF6);
    chk("rd.R2", regVal, 8'h55);

    // Opcode sweep
    for (int op = 1; op < 8; op++) step("sweep", 8'(op * 32), 8'h00, 1'b0, 8'(op));
    step("bne", 8'hC0, 8'h00, 1'b0, 8'h00);
    chk("bne.JC_NEQ", {JC, NEQ, funct}, {2'b11, 3'd1});
    step("ioout", 8'hF0, 8'h00, 1'b0, 8'h00);
    chk("ioout.SOUT", {J, JC, INA, RM, WM, SIN, SOUT, WROut, NEQ}, 9'b000000100);

    // Sign extension and PC wrap
    step("sx0", 8'h2F, 8'h00, 1'b0, 8'h00);
    chk("sx.0F", extsinal, 8'h0F);
    step("sx1", 8'h30, 8'h00, 1'b0, 8'hFF);
    chk("sx.F0", extsinal, 8'hF0);
    chk("pc.wrap", PCout, 8'h00);

    // Async reset mid-operation wipes R3 and blocks a pending write
    step("wrR3", 8'h03, 8'hAA, 1'b1, 8'h00);
    @(negedge clock);
    chk("R3.AA", regVal, 8'hAA);
    WR = 1'b1; data = 8'h77;
    #1;
    reset_n = 1'b0;
    for (int k = 0; k < 4; k++) mreg[k] = 8'h00;
    #1;
    chk("arst.regVal", regVal, 8'h00);
    chk("arst.strobes", {J, JC, INA, RM, WM, SIN, SOUT, WROut, NEQ}, 9'd0);
    @(posedge clock);
    @(negedge clock);
    WR = 1'b0;
    reset_n = 1'b1;
    #2;
    chk("arst.R3", regVal, 8'h00);

    // Randomized traffic with occasional async reset pulses
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      inst = 8'($urandom); data = 8'($urandom); WR = 1'($urandom);
      PC = 8'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        reset_n = 1'b0;
        for (int k = 0; k < 4; k++) mreg[k] = 8'h00;
      end else begin
        reset_n = 1'b1;
      end
      #2;
      check_all("rnd");
      @(posedge clock);
      if (WR && reset_n) mreg[inst[1:0]] = data;
    end
    @(negedge clock);
    reset_n = 1'b1; WR = 1'b0;
    for (int k = 0; k < 4; k++) begin
      inst = 8'(k);
      #1;
      chk("final.reg", regVal, mreg[k]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
